// File: rtl/ps2_pkg.sv
// Shared types, constants and helpers for the PS/2 mouse packet transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT_INH,
    ST_DONE
  } tx_state_t;

  localparam int FRAME_LEN = 11;

  localparam int B0_YOVF    = 7;
  localparam int B0_XOVF    = 6;
  localparam int B0_YSIGN   = 5;
  localparam int B0_XSIGN   = 4;
  localparam int B0_ALWAYS1 = 3;

  // Clamp to [-256,255]; a 10-bit value fits in 9 bits iff its top two bits agree.
  function automatic logic [9:0] sat9(input logic signed [9:0] v);
    if (v[9] != v[8]) return {1'b1, (v[9] ? 9'h100 : 9'h0FF)};
    return {1'b0, v[8:0]};
  endfunction

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Single-byte PS/2 serializer: start, 8 data LSB first, odd parity, stop.
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       abort,
  input  logic [7:0] data,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       stop_bit,
  output logic       frame_done
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [3:0]    BIT_LAST = 4'(FRAME_LEN - 1);

  logic                 active;
  logic [FRAME_LEN-1:0] frame;
  logic [3:0]           bit_cnt;
  logic [DW-1:0]        div_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      frame   <= '1;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (abort) begin
      active  <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (load) begin
      active  <= 1'b1;
      frame   <= {1'b1, odd_parity(data), data, 1'b0};
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (active) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        if (bit_cnt == BIT_LAST) begin
          active  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Data changes only at the bit boundary, i.e. during the high clock half.
  assign stop_bit   = active && (bit_cnt == BIT_LAST);
  assign frame_done = stop_bit && (div_cnt == DIV_LAST);
  assign ps2_clk    = !active || (div_cnt < DIV_HALF);
  assign ps2_data   = !active || frame[bit_cnt];

endmodule

// File: rtl/ps2_mouse_tx.sv
// Device-side PS/2 mouse transmitter: formats a report into 3 bytes and sends them with host-inhibit handling.
module ps2_mouse_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [2:0]        buttons,
  input  logic signed [9:0] dx,
  input  logic signed [9:0] dy,
  input  logic              host_inhibit,
  output logic              ps2_clk_o,
  output logic              ps2_data_o,
  output logic              pkt_done,
  output logic              busy
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  tx_state_t       state_q, state_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [2:0][7:0] pkt_q, fmt;
  logic [9:0]      xs, ys;
  logic [7:0]      load_data;
  logic            capture, load, abort, stop_bit, frame_done;

  assign xs = sat9(dx);
  assign ys = sat9(dy);

  always_comb begin
    fmt                  = '0;
    fmt[0][2:0]          = buttons;
    fmt[0][B0_ALWAYS1]   = 1'b1;
    fmt[0][B0_XSIGN]     = xs[8];
    fmt[0][B0_YSIGN]     = ys[8];
    fmt[0][B0_XOVF]      = xs[9];
    fmt[0][B0_YOVF]      = ys[9];
    fmt[1]               = xs[7:0];
    fmt[2]               = ys[7:0];
  end

  assign pkt_ready = (state_q == ST_IDLE) && !host_inhibit;
  assign pkt_done  = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    capture    = 1'b0;
    load       = 1'b0;
    abort      = 1'b0;
    case (byte_idx_q)
      2'd1:    load_data = pkt_q[1];
      2'd2:    load_data = pkt_q[2];
      default: load_data = pkt_q[0];
    endcase
    case (state_q)
      ST_IDLE: begin
        load_data = fmt[0];
        if (pkt_valid && pkt_ready) begin
          capture    = 1'b1;
          load       = 1'b1;
          byte_idx_d = 2'd0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        // An inhibit that lands on the stop bit lets the frame finish.
        if (host_inhibit && !stop_bit) begin
          abort      = 1'b1;
          byte_idx_d = 2'd0;
          gap_cnt_d  = '0;
          state_d    = ST_WAIT_INH;
        end else if (frame_done) begin
          gap_cnt_d = '0;
          if (byte_idx_q == 2'd2) begin
            state_d = ST_DONE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = ST_GAP;
          end
        end
      end
      ST_GAP, ST_WAIT_INH: begin
        // byte_idx already names the byte to send next (0 after an abort).
        if (host_inhibit) begin
          gap_cnt_d = '0;
          state_d   = ST_WAIT_INH;
        end else if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          load      = 1'b1;
          state_d   = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      if (capture) pkt_q <= fmt;
    end
  end

  ps2_frame_tx #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .abort      (abort),
    .data       (load_data),
    .ps2_clk    (ps2_clk_o),
    .ps2_data   (ps2_data_o),
    .stop_bit   (stop_bit),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_ps2_mouse_tx.sv
// Directed bench for ps2_mouse_tx: decodes the PS/2 lines and checks bytes, timing and inhibit handling.
module tb_ps2_mouse_tx;

  localparam int CLK_DIV    = 8;
  localparam int GAP_CYCLES = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pkt_valid = 1'b0;
  logic       host_inhibit = 1'b0;
  logic [2:0] buttons = '0;
  logic [9:0] dx = '0;
  logic [9:0] dy = '0;
  logic       pkt_ready, ps2_clk_o, ps2_data_o, pkt_done, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ps2_mouse_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .buttons      (buttons),
    .dx           (dx),
    .dy           (dy),
    .host_inhibit (host_inhibit),
    .ps2_clk_o    (ps2_clk_o),
    .ps2_data_o   (ps2_data_o),
    .pkt_done     (pkt_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: a bit is taken on each falling ps2 clock; a long idle drops a partial frame.
  logic        prev_clk = 1'b1;
  logic [10:0] sh = '0;
  int          nbits = 0, idle_run = 0, falls = 0;
  int          done_cnt = 0, done_cyc = -1, frame_err = 0;
  logic [7:0]  rx_q[$];
  logic        par_q[$];

  always @(negedge clk) begin
    if (prev_clk && !ps2_clk_o) begin
      falls++;
      sh[nbits] = ps2_data_o;
      nbits++;
      if (nbits == 11) begin
        if (sh[0] !== 1'b0 || sh[10] !== 1'b1 || sh[9] !== ~^sh[8:1]) frame_err++;
        rx_q.push_back(sh[8:1]);
        par_q.push_back(sh[9]);
        nbits = 0;
      end
    end
    if (ps2_clk_o && ps2_data_o) idle_run++;
    else idle_run = 0;
    if (idle_run >= CLK_DIV && nbits != 0) nbits = 0;
    if (pkt_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_clk = ps2_clk_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic at_cyc(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic send(input logic [2:0] b, input int x, input int y, output int n);
    int g;
    g = 0;
    @(negedge clk);
    while (pkt_ready !== 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    vectors++;
    if (pkt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_ready: pkt_ready=%b want 1", pkt_ready);
    end
    buttons = b; dx = x[9:0]; dy = y[9:0]; pkt_valid = 1'b1; n = cyc;
    @(posedge clk);
    #1 pkt_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ps2_clk_o, ps2_data_o, busy, pkt_done} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_outputs: clk,data,busy,done=%b want 1100", {ps2_clk_o, ps2_data_o, busy, pkt_done});
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({pkt_ready, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_ready: ready,busy=%b want 10", {pkt_ready, busy});
    end
  endtask

  task automatic test_basic;
    int n, rb, d0, fe0;
    logic [7:0] e[3];
    logic ep[3];
    e = '{8'h29, 8'h05, 8'hFD};
    ep = '{1'b0, 1'b1, 1'b0};
    rb = rx_q.size(); d0 = done_cnt; fe0 = frame_err;
    send(3'b001, 5, -3, n);
    at_cyc(n + 1);
    vectors++;
    if ({busy, ps2_clk_o, ps2_data_o} !== 3'b110) begin
      miscompares++;
      $display("FAIL basic_start: busy,clk,data=%b want 110", {busy, ps2_clk_o, ps2_data_o});
    end
    at_cyc(n + 272);
    vectors++;
    if (pkt_done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_early: pkt_done=%b want 0 at N+272", pkt_done);
    end
    at_cyc(n + 273);
    vectors++;
    if ({pkt_done, pkt_ready, busy} !== 3'b101) begin
      miscompares++;
      $display("FAIL basic_done: done,ready,busy=%b want 101 at N+273", {pkt_done, pkt_ready, busy});
    end
    at_cyc(n + 274);
    vectors++;
    if ({pkt_done, pkt_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL basic_ready: done,ready,busy=%b want 010 at N+274", {pkt_done, pkt_ready, busy});
    end
    #1;
    vectors++;
    if (done_cnt - d0 != 1 || done_cyc != n + 273) begin
      miscompares++;
      $display("FAIL basic_done_count: count=%0d cyc=%0d want 1 at %0d", done_cnt - d0, done_cyc, n + 273);
    end
    vectors++;
    if (rx_q.size() != rb + 3) begin
      miscompares++;
      $display("FAIL basic_nbytes: got %0d want 3", rx_q.size() - rb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (rx_q[rb+i] !== e[i] || par_q[rb+i] !== ep[i]) begin
          miscompares++;
          $display("FAIL basic_byte%0d: got %h/p%b want %h/p%b", i, rx_q[rb+i], par_q[rb+i], e[i], ep[i]);
        end
      end
    end
    vectors++;
    if (frame_err != fe0) begin
      miscompares++;
      $display("FAIL basic_framing: errors=%0d want 0", frame_err - fe0);
    end
  endtask

  task automatic test_saturation;
    int n, rb, d0, g;
    logic [7:0] e[6];
    e = '{8'hE8, 8'hFF, 8'h00, 8'h18, 8'h00, 8'hFF};
    rb = rx_q.size(); d0 = done_cnt;
    send(3'b000, 300, -300, n);
    send(3'b000, -256, 255, n);
    g = 0;
    while (done_cnt < d0 + 2 && g < 2000) begin @(negedge clk); #1; g++; end
    vectors++;
    if (done_cnt != d0 + 2 || rx_q.size() != rb + 6) begin
      miscompares++;
      $display("FAIL sat_count: done=%0d bytes=%0d want 2 and 6", done_cnt - d0, rx_q.size() - rb);
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (rx_q[rb+i] !== e[i]) begin
          miscompares++;
          $display("FAIL sat_byte%0d: got %h want %h", i, rx_q[rb+i], e[i]);
        end
      end
    end
  endtask

  task automatic test_abort;
    int n, rb, d0, f0, g;
    logic [7:0] e[4];
    e = '{8'h29, 8'h29, 8'h05, 8'hFD};
    rb = rx_q.size(); d0 = done_cnt;
    send(3'b001, 5, -3, n);
    // byte1 starts at N+93; data bit 3 spans N+125..N+132
    at_cyc(n + 130);
    vectors++;
    if (ps2_clk_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pre: ps2_clk=%b want 0 at N+130", ps2_clk_o);
    end
    host_inhibit = 1'b1;
    at_cyc(n + 131);
    f0 = falls;
    vectors++;
    if ({ps2_clk_o, ps2_data_o, busy} !== 3'b111) begin
      miscompares++;
      $display("FAIL abort_release: clk,data,busy=%b want 111", {ps2_clk_o, ps2_data_o, busy});
    end
    at_cyc(n + 150);
    host_inhibit = 1'b0;
    at_cyc(n + 153);
    vectors++;
    if ({ps2_clk_o, ps2_data_o, falls - f0} !== {2'b11, 32'd0}) begin
      miscompares++;
      $display("FAIL abort_idle: clk,data=%b falls=%0d want 11 and 0", {ps2_clk_o, ps2_data_o}, falls - f0);
    end
    at_cyc(n + 154);
    vectors++;
    if ({ps2_clk_o, ps2_data_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_restart: clk,data=%b want 10 at N+154", {ps2_clk_o, ps2_data_o});
    end
    g = 0;
    while (done_cnt < d0 + 1 && g < 2000) begin @(negedge clk); #1; g++; end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (done_cnt != d0 + 1 || done_cyc != n + 426) begin
      miscompares++;
      $display("FAIL abort_done: count=%0d cyc=%0d want 1 at %0d", done_cnt - d0, done_cyc, n + 426);
    end
    vectors++;
    if (rx_q.size() != rb + 4) begin
      miscompares++;
      $display("FAIL abort_nbytes: got %0d want 4", rx_q.size() - rb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (rx_q[rb+i] !== e[i]) begin
          miscompares++;
          $display("FAIL abort_byte%0d: got %h want %h", i, rx_q[rb+i], e[i]);
        end
      end
    end
  endtask

  task automatic test_gap_inhibit;
    int n, rb, d0, g;
    logic [7:0] e[3];
    e = '{8'h29, 8'h05, 8'hFD};
    rb = rx_q.size(); d0 = done_cnt;
    send(3'b001, 5, -3, n);
    at_cyc(n + 90);
    host_inhibit = 1'b1;
    at_cyc(n + 99);
    vectors++;
    if ({pkt_ready, busy, ps2_clk_o, ps2_data_o} !== 4'b0111) begin
      miscompares++;
      $display("FAIL gap_hold: ready,busy,clk,data=%b want 0111", {pkt_ready, busy, ps2_clk_o, ps2_data_o});
    end
    at_cyc(n + 100);
    host_inhibit = 1'b0;
    at_cyc(n + 103);
    vectors++;
    if ({ps2_clk_o, ps2_data_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL gap_idle: clk,data=%b want 11 at N+103", {ps2_clk_o, ps2_data_o});
    end
    at_cyc(n + 104);
    vectors++;
    if ({ps2_clk_o, ps2_data_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL gap_resume: clk,data=%b want 10 at N+104", {ps2_clk_o, ps2_data_o});
    end
    g = 0;
    while (done_cnt < d0 + 1 && g < 2000) begin @(negedge clk); #1; g++; end
    vectors++;
    if (done_cnt != d0 + 1 || done_cyc != n + 284) begin
      miscompares++;
      $display("FAIL gap_done: count=%0d cyc=%0d want 1 at %0d", done_cnt - d0, done_cyc, n + 284);
    end
    vectors++;
    if (rx_q.size() != rb + 3) begin
      miscompares++;
      $display("FAIL gap_nbytes: got %0d want 3", rx_q.size() - rb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (rx_q[rb+i] !== e[i]) begin
          miscompares++;
          $display("FAIL gap_byte%0d: got %h want %h", i, rx_q[rb+i], e[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, m, rb, d0, f0, g;
    logic [7:0] e[6];
    e = '{8'h29, 8'h05, 8'hFD, 8'hE8, 8'hFF, 8'h00};
    rb = rx_q.size(); d0 = done_cnt; f0 = falls;
    @(negedge clk);
    buttons = 3'b001; dx = 10'd5; dy = 10'h3FD; pkt_valid = 1'b1; n = cyc;
    @(posedge clk);
    #1;
    buttons = 3'b000; dx = 10'd300; dy = 10'h2D4;
    g = 0;
    @(negedge clk);
    while (pkt_ready !== 1'b1 && g < 1000) begin @(negedge clk); g++; end
    m = cyc;
    @(posedge clk);
    #1 pkt_valid = 1'b0;
    vectors++;
    if (m != n + 274) begin
      miscompares++;
      $display("FAIL b2b_capture: second capture at %0d want %0d", m, n + 274);
    end
    g = 0;
    while (done_cnt < d0 + 2 && g < 2000) begin @(negedge clk); #1; g++; end
    vectors++;
    if (done_cnt != d0 + 2 || done_cyc != m + 273) begin
      miscompares++;
      $display("FAIL b2b_done: count=%0d cyc=%0d want 2 at %0d", done_cnt - d0, done_cyc, m + 273);
    end
    vectors++;
    if (falls - f0 != 66) begin
      miscompares++;
      $display("FAIL b2b_falls: got %0d want 66", falls - f0);
    end
    vectors++;
    if (rx_q.size() != rb + 6) begin
      miscompares++;
      $display("FAIL b2b_nbytes: got %0d want 6", rx_q.size() - rb);
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (rx_q[rb+i] !== e[i]) begin
          miscompares++;
          $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[rb+i], e[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    int n, rb, d0, g;
    logic [7:0] e[3];
    e = '{8'h29, 8'h05, 8'hFD};
    send(3'b001, 5, -3, n);
    // byte2 starts at N+185; data bit 5 spans N+233..N+240
    at_cyc(n + 237);
    vectors++;
    if ({ps2_clk_o, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_pre: clk,busy=%b want 01 at N+237", {ps2_clk_o, busy});
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({ps2_clk_o, ps2_data_o, busy, pkt_done} !== 4'b1100) begin
      miscompares++;
      $display("FAIL rst_async: clk,data,busy,done=%b want 1100", {ps2_clk_o, ps2_data_o, busy, pkt_done});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    rb = rx_q.size(); d0 = done_cnt;
    send(3'b001, 5, -3, n);
    g = 0;
    while (done_cnt < d0 + 1 && g < 2000) begin @(negedge clk); #1; g++; end
    vectors++;
    if (done_cnt != d0 + 1 || done_cyc != n + 273) begin
      miscompares++;
      $display("FAIL rst_after_done: count=%0d cyc=%0d want 1 at %0d", done_cnt - d0, done_cyc, n + 273);
    end
    vectors++;
    if (rx_q.size() != rb + 3) begin
      miscompares++;
      $display("FAIL rst_after_nbytes: got %0d want 3", rx_q.size() - rb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (rx_q[rb+i] !== e[i]) begin
          miscompares++;
          $display("FAIL rst_after_byte%0d: got %h want %h", i, rx_q[rb+i], e[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_abort();
    test_gap_inhibit();
    test_back_to_back();
    test_reset_midframe();
    vectors++;
    if (frame_err != 0) begin
      miscompares++;
      $display("FAIL framing_total: errors=%0d want 0", frame_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_tx.md
Name: ps2_mouse_tx

Overview:
- Device-side PS/2 mouse packet transmitter; the counterpart of the team's 3-byte PS/2 packet framing receiver.
- Accepts one movement/button report per valid/ready handshake and formats it into the standard 3-byte mouse packet.
- Serializes each byte as an 11-bit PS/2 frame on driven clock/data lines.
- Used in the testcase environment as a stimulus source for packet receivers, and as a device model.

Parameters:
- CLK_DIV, 8, system cycles per PS/2 bit; even, >=4. ps2_clk_o is high for the first CLK_DIV/2 cycles and low for the second half.
- GAP_CYCLES, 4, idle cycles (both lines high) between bytes of one packet and after an inhibit release; >=1.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- pkt_valid  in  1  report available
- pkt_ready  out  1  block can accept a report
- buttons  in  3  {middle, right, left}
- dx  in  10  signed X movement
- dy  in  10  signed Y movement
- host_inhibit  in  1  host holding the bus (clock pulled low); synchronous to clk
- ps2_clk_o  out  1  PS/2 clock, idle 1
- ps2_data_o  out  1  PS/2 data, idle 1
- pkt_done  out  1  one-cycle pulse when a packet has fully completed
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; ps2_clk_o=1, ps2_data_o=1, pkt_done=0, busy=0; all counters cleared; captured packet discarded.
- pkt_ready = (state==IDLE) && !host_inhibit. This is combinational from registered state.
- Capture: when pkt_valid && pkt_ready in cycle N, the block registers the three bytes, and the first SEND cycle is N+1.
- Formatting, per axis:
  - dx and dy saturate to [-256,255]. An axis overflow bit is set iff saturation occurred.
  - The sign bit is bit 8 of the saturated value; the data byte is its low 8 bits.
  - byte0 = {y_ovf, x_ovf, y_sign, x_sign, 1'b1, buttons}.
  - byte1 = X data byte.
  - byte2 = Y data byte.
- Frame: bits sent in this order:
  - start bit 0
  - data[0..7], LSB first
  - odd parity (= ~^byte)
  - stop bit 1
  - Each bit occupies CLK_DIV cycles. ps2_data_o changes only at the start of a bit period, while ps2_clk_o is high.
- States:
  - IDLE -> SEND on handshake (byte_idx=0).
  - SEND -> GAP after stop bit, if byte_idx<2.
  - SEND -> DONE after the stop bit of byte 2.
  - GAP -> SEND after GAP_CYCLES, with byte_idx+1.
  - DONE lasts exactly 1 cycle (pkt_done=1, busy=1), then -> IDLE.
  - WAIT_INH, with restart or resume as described below.
- Default timing: capture at N; DONE at N+273; pkt_ready=1 at N+274. Total = 33*CLK_DIV + 2*GAP_CYCLES + 1 cycles after capture.
- Inhibit during SEND, bits 0..9: abort the frame and release both lines to 1 the next cycle. Go to WAIT_INH. On release, wait GAP_CYCLES, then restart from byte0 with the held packet. No pkt_done is issued for the aborted attempt.
- Inhibit during the stop bit (bit 10): the frame completes normally; the inhibit is then honoured in GAP.
- Inhibit during GAP: enter WAIT_INH. On release, wait GAP_CYCLES, then resume with the next byte (completed bytes are not resent).
- Inhibit during DONE: ignored; the block returns to IDLE, where pkt_ready stays 0 while inhibited.
- Inhibit while IDLE: there is no handshake; pkt_valid is held off by pkt_ready=0.
- Reset mid-packet: outputs return to idle levels immediately. A partially sent frame is truncated and never resumed.

Decomposition:
- ps2_pkg holds:
  - tx state enum (IDLE, SEND, GAP, WAIT_INH, DONE)
  - frame length constant 11
  - byte0 bit-position constants
  - function sat9(input signed [9:0]) returning {ovf, value[8:0]}
  - function odd_parity(byte)
- Sub-module ps2_frame_tx (single-byte serializer with start/load, abort, bit/divider counters and a frame_done pulse).
- ps2_mouse_tx owns the packet FSM, formatting and inhibit policy.

Test Plan:
- Basic packet: buttons=3'b001, dx=5, dy=-3, handshake at N -> bytes 0x29, 0x05, 0xFD; parity bits 0, 1, 0; pkt_done only at N+273; pkt_ready back at N+274.
- Saturation: dx=300, dy=-300 -> byte0=0xE8, byte1=0xFF, byte2=0x00. Then dx=-256, dy=255 -> byte0=0x18 (no ovf), byte1=0x00, byte2=0xFF.
- Abort mid-byte: host_inhibit high for 20 cycles during byte1 data bit 3 -> lines high the next cycle; after release, 4 idle cycles; the whole packet is resent from byte0 (0x29...); exactly one pkt_done.
- Inhibit in GAP after byte0 -> on release, 4 idle cycles, then byte1 only (byte0 not repeated); one pkt_done.
- Back-to-back: pkt_valid held high with two reports -> second captured the cycle pkt_ready rises; no lost/duplicated bytes; ps2_clk_o has exactly 66 falling edges total.
- Async reset mid-frame (byte2, bit 5): ps2_clk_o=ps2_data_o=1, busy=0, pkt_done=0 without waiting for a clk edge; the next report transmits cleanly.
